// File: rtl/reflet_ram_responder_pkg.sv
// Shared constants and helpers for the Reflet RAM responder.
package reflet_ram_responder_pkg;
  localparam int REFLET_RAM_MAX_LATENCY = 2;
  localparam int REFLET_RAM_CNT_W = 2;
  localparam int REFLET_RAM_ERR_W = 8;
  localparam logic [REFLET_RAM_ERR_W-1:0] REFLET_RAM_ERR_MAX = '1;

  function automatic logic [REFLET_RAM_ERR_W-1:0] err_sat_inc(input logic [REFLET_RAM_ERR_W-1:0] value);
    return (value == REFLET_RAM_ERR_MAX) ? value : value + 1'b1;
  endfunction
endpackage

// File: rtl/reflet_ram_array.sv
// Storage for one RAM window: one write port, one registered read port.
module reflet_ram_array #(
  parameter int width = 16,
  parameter int addr_bits = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [addr_bits-1:0] waddr,
  input  logic [width-1:0]     wdata,
  input  logic [addr_bits-1:0] raddr,
  output logic [width-1:0]     rdata
);
  logic [width-1:0] mem [2**addr_bits];

  // Read-first: a same-edge write is resolved by the responder's forwarding.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/reflet_ram_responder.sv
// Reflet RAM responder: windowed sync RAM, forwarded read pipeline, stability flag.
// Out-of-range error tracking is built when REFLET_RAM_ERR_EN is defined.
module reflet_ram_responder
  import reflet_ram_responder_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int addr_bits = 8,
  parameter logic [wordsize-1:0] base_addr = '0,
  parameter int read_latency = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [wordsize-1:0]         addr,
  input  logic [wordsize-1:0]         data_in,
  input  logic                        write_en,
  output logic [wordsize-1:0]         data_out,
  output logic                        data_valid,
  output logic                        in_range,
  output logic                        err_flag,
  output logic [REFLET_RAM_ERR_W-1:0] err_count
);
  localparam int LAT = (read_latency > REFLET_RAM_MAX_LATENCY) ? REFLET_RAM_MAX_LATENCY : read_latency;
  localparam logic [REFLET_RAM_CNT_W-1:0] LAT_CNT = REFLET_RAM_CNT_W'(LAT);

  logic [addr_bits-1:0]        idx;
  logic                        wr_go;
  logic [wordsize-1:0]         rd_data;
  logic [wordsize-1:0]         a_val;
  logic [wordsize-1:0]         s1_next;
  logic                        a_ok_reg;
  logic                        a_fwd_reg;
  logic [addr_bits-1:0]        a_idx_reg;
  logic [wordsize-1:0]         a_wdata_reg;
  logic                        s1_ok_reg;
  logic [addr_bits-1:0]        s1_idx_reg;
  logic [wordsize-1:0]         s1_reg;
  logic [wordsize-1:0]         prev_addr_reg;
  logic [REFLET_RAM_CNT_W-1:0] cnt_reg;
  logic [REFLET_RAM_CNT_W-1:0] cnt_next;
  logic                        addr_same;
  logic                        cnt_full;

  assign idx      = addr[addr_bits-1:0];
  assign in_range = (addr[wordsize-1:addr_bits] == base_addr[wordsize-1:addr_bits]);
  assign wr_go    = enable & write_en & in_range & reset;

  reflet_ram_array #(
    .width(wordsize),
    .addr_bits(addr_bits)
  ) u_array (
    .clk(clk),
    .en(enable),
    .we(wr_go),
    .waddr(idx),
    .wdata(data_in),
    .raddr(idx),
    .rdata(rd_data)
  );

  // Each stage picks up a write landing on its index during the edge it advances.
  always_comb begin
    a_val   = a_fwd_reg ? a_wdata_reg : rd_data;
    s1_next = '0;
    if (a_ok_reg) begin
      s1_next = (wr_go && (idx == a_idx_reg)) ? data_in : a_val;
    end
  end

  assign addr_same  = (addr == prev_addr_reg);
  assign cnt_full   = (cnt_reg == LAT_CNT);
  assign data_valid = cnt_full & addr_same;

  always_comb begin
    cnt_next = '0;
    if (addr_same) begin
      cnt_next = cnt_full ? cnt_reg : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_ok_reg      <= 1'b0;
      a_fwd_reg     <= 1'b0;
      a_idx_reg     <= '0;
      a_wdata_reg   <= '0;
      s1_ok_reg     <= 1'b0;
      s1_idx_reg    <= '0;
      s1_reg        <= '0;
      prev_addr_reg <= '0;
      cnt_reg       <= '0;
    end else if (enable) begin
      a_ok_reg      <= in_range;
      a_fwd_reg     <= wr_go;
      a_idx_reg     <= idx;
      a_wdata_reg   <= data_in;
      s1_ok_reg     <= a_ok_reg;
      s1_idx_reg    <= a_idx_reg;
      s1_reg        <= s1_next;
      prev_addr_reg <= addr;
      cnt_reg       <= cnt_next;
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic [wordsize-1:0] s2_reg;
      logic [wordsize-1:0] s2_next;

      always_comb begin
        s2_next = '0;
        if (s1_ok_reg) begin
          s2_next = (wr_go && (idx == s1_idx_reg)) ? data_in : s1_reg;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s2_reg <= '0;
        end else if (enable) begin
          s2_reg <= s2_next;
        end
      end

      assign data_out = s2_reg;
    end else begin : g_lat1
      assign data_out = s1_reg;
    end
  endgenerate

`ifdef REFLET_RAM_ERR_EN
  logic                        err_flag_reg;
  logic [REFLET_RAM_ERR_W-1:0] err_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_flag_reg  <= 1'b0;
      err_count_reg <= '0;
    end else if (enable && !in_range) begin
      if (write_en || data_valid) begin
        err_flag_reg <= 1'b1;
      end
      if (write_en) begin
        err_count_reg <= err_sat_inc(err_count_reg);
      end
    end
  end

  assign err_flag  = err_flag_reg;
  assign err_count = err_count_reg;
`else
  assign err_flag  = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_reflet_ram_responder.sv
// Bench for reflet_ram_responder: latency-2 and latency-1 instances driven in parallel.
module tb_reflet_ram_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        write_en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;

  logic [15:0] data_out2, data_out1;
  logic        data_valid2, data_valid1;
  logic        in_range2, in_range1;
  logic        err_flag2, err_flag1;
  logic [7:0]  err_count2, err_count1;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;

`ifdef REFLET_RAM_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    int         due;
    logic [7:0] idx;
    bit         ok;
  } item_t;

  item_t       q1[$];
  item_t       q2[$];
  logic [15:0] model_mem [256];
  bit          model_known [256];

  always #5 clk = ~clk;

  reflet_ram_responder #(.wordsize(16), .addr_bits(8), .base_addr(16'h0000), .read_latency(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
    .write_en(write_en), .data_out(data_out2), .data_valid(data_valid2),
    .in_range(in_range2), .err_flag(err_flag2), .err_count(err_count2)
  );

  reflet_ram_responder #(.wordsize(16), .addr_bits(8), .base_addr(16'h0000), .read_latency(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
    .write_en(write_en), .data_out(data_out1), .data_valid(data_valid1),
    .in_range(in_range1), .err_flag(err_flag1), .err_count(err_count1)
  );

  // Scoreboard: reads are queued at their sampling edge; the expected word is the
  // model memory as it stands after the edge the result is due.
  always @(posedge clk) begin : mon
    item_t       it;
    logic [15:0] exp_d;
    if (!reset) begin
      q1.delete();
      q2.delete();
    end else if (enable) begin
      if (write_en && (addr[15:8] == 8'h00)) begin
        model_mem[addr[7:0]]   = data_in;
        model_known[addr[7:0]] = 1'b1;
      end
      en_cnt++;
      q1.push_back('{due: en_cnt + 1, idx: addr[7:0], ok: (addr[15:8] == 8'h00)});
      q2.push_back('{due: en_cnt + 2, idx: addr[7:0], ok: (addr[15:8] == 8'h00)});
      #1;
      while (q1.size() > 0 && q1[0].due == en_cnt) begin
        it = q1.pop_front();
        if (!it.ok || model_known[it.idx]) begin
          exp_d = it.ok ? model_mem[it.idx] : 16'h0000;
          checks++;
          if (data_out1 !== exp_d) begin
            failures++;
            $display("FAIL sb_lat1 idx=%02h ok=%0d got=%04h exp=%04h", it.idx, it.ok, data_out1, exp_d);
          end else begin
            $display("sb lat1 idx=%02h ok=%0d data=%04h", it.idx, it.ok, data_out1);
          end
        end
      end
      while (q2.size() > 0 && q2[0].due == en_cnt) begin
        it = q2.pop_front();
        if (!it.ok || model_known[it.idx]) begin
          exp_d = it.ok ? model_mem[it.idx] : 16'h0000;
          checks++;
          if (data_out2 !== exp_d) begin
            failures++;
            $display("FAIL sb_lat2 idx=%02h ok=%0d got=%04h exp=%04h", it.idx, it.ok, data_out2, exp_d);
          end else begin
            $display("sb lat2 idx=%02h ok=%0d data=%04h", it.idx, it.ok, data_out2);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    enable = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({data_out2, data_valid2, err_flag2, err_count2} !== 26'h0) begin
      failures++;
      $display("FAIL reset_state2 got=%07h exp=0", {data_out2, data_valid2, err_flag2, err_count2});
    end
    checks++;
    if ({data_out1, data_valid1, err_flag1, err_count1} !== 26'h0) begin
      failures++;
      $display("FAIL reset_state1 got=%07h exp=0", {data_out1, data_valid1, err_flag1, err_count1});
    end
    tick();
    tick();
    reset = 1'b1;
    addr = 16'h0020; data_in = 16'h1234; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    tick();
    tick();
    checks++;
    if (data_out2 !== 16'h1234 || data_out1 !== 16'h1234) begin
      failures++;
      $display("FAIL pre_reset_data got=%04h/%04h exp=1234", data_out2, data_out1);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({data_out2, data_valid2, data_out1, data_valid1} !== 34'h0) begin
      failures++;
      $display("FAIL async_reset got=%04h,%0d/%04h,%0d exp=0", data_out2, data_valid2, data_out1, data_valid1);
    end
    @(negedge clk);
    reset = 1'b1;
    addr = 16'h0010;
    for (int n = 1; n <= 3; n++) begin
      logic e1, e2;
      tick();
      e1 = (n >= 2);
      e2 = (n >= 3);
      checks++;
      if (data_valid1 !== e1) begin
        failures++;
        $display("FAIL valid_after_reset1 edge=%0d got=%0d exp=%0d", n, data_valid1, e1);
      end
      checks++;
      if (data_valid2 !== e2) begin
        failures++;
        $display("FAIL valid_after_reset2 edge=%0d got=%0d exp=%0d", n, data_valid2, e2);
      end
    end
  endtask

  task automatic test_write_read();
    addr = 16'h0005; data_in = 16'hBEEF; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    addr = 16'h0006;
    tick();
    addr = 16'h0005;
    tick();
    checks++;
    if (data_valid1 !== 1'b0 || data_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL wr_valid_early got=%0d/%0d exp=0/0", data_valid2, data_valid1);
    end
    tick();
    checks++;
    if (data_out1 !== 16'hBEEF || data_valid1 !== 1'b1) begin
      failures++;
      $display("FAIL wr_read_lat1 got=%04h,%0d exp=beef,1", data_out1, data_valid1);
    end
    tick();
    checks++;
    if (data_out2 !== 16'hBEEF || data_valid2 !== 1'b1) begin
      failures++;
      $display("FAIL wr_read_lat2 got=%04h,%0d exp=beef,1", data_out2, data_valid2);
    end
  endtask

  task automatic test_forward();
    addr = 16'h0007; data_in = 16'h1111; write_en = 1'b1;
    tick();
    addr = 16'h0008; data_in = 16'h0808;
    tick();
    addr = 16'h0007; data_in = 16'hAAAA;
    for (int n = 0; n < 3; n++) begin
      tick();
      write_en = 1'b0;
      checks++;
      if (data_out1 === 16'h1111 || data_out2 === 16'h1111) begin
        failures++;
        $display("FAIL fwd_stale step=%0d got=%04h/%04h exp=not 1111", n, data_out2, data_out1);
      end
    end
    checks++;
    if (data_out1 !== 16'hAAAA || data_out2 !== 16'hAAAA) begin
      failures++;
      $display("FAIL fwd_same_edge got=%04h/%04h exp=aaaa", data_out2, data_out1);
    end
    addr = 16'h0009; data_in = 16'h0909; write_en = 1'b1;
    tick();
    addr = 16'h0007; write_en = 1'b0;
    tick();
    data_in = 16'hCCCC; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    tick();
    tick();
    checks++;
    if (data_out1 !== 16'hCCCC || data_out2 !== 16'hCCCC) begin
      failures++;
      $display("FAIL fwd_late_stage got=%04h/%04h exp=cccc", data_out2, data_out1);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp_c;
    addr = 16'h0000; data_in = 16'h0F0F; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    addr = 16'h00FF;
    #1;
    checks++;
    if (in_range2 !== 1'b1 || in_range1 !== 1'b1) begin
      failures++;
      $display("FAIL in_range_top got=%0d/%0d exp=1", in_range2, in_range1);
    end
    addr = 16'h0100; data_in = 16'h5555; write_en = 1'b1;
    #1;
    checks++;
    if (in_range2 !== 1'b0 || in_range1 !== 1'b0) begin
      failures++;
      $display("FAIL in_range_over got=%0d/%0d exp=0", in_range2, in_range1);
    end
    tick();
    write_en = 1'b0;
    exp_c = ERR_ON ? 8'd1 : 8'd0;
    checks++;
    if (err_flag2 !== ERR_ON || err_count2 !== exp_c || err_flag1 !== ERR_ON || err_count1 !== exp_c) begin
      failures++;
      $display("FAIL err_first got=%0d,%0d/%0d,%0d exp=%0d,%0d", err_flag2, err_count2, err_flag1, err_count1, ERR_ON, exp_c);
    end
    tick();
    tick();
    checks++;
    if (data_out2 !== 16'h0000 || data_out1 !== 16'h0000) begin
      failures++;
      $display("FAIL oor_read got=%04h/%04h exp=0000", data_out2, data_out1);
    end
    addr = 16'h0000;
    repeat (3) tick();
    checks++;
    if (data_out2 !== 16'h0F0F || data_out1 !== 16'h0F0F) begin
      failures++;
      $display("FAIL oor_no_alias got=%04h/%04h exp=0f0f", data_out2, data_out1);
    end
    addr = 16'h0100; write_en = 1'b1;
    repeat (299) tick();
    write_en = 1'b0;
    exp_c = ERR_ON ? 8'd255 : 8'd0;
    checks++;
    if (err_count2 !== exp_c || err_count1 !== exp_c || err_flag2 !== ERR_ON) begin
      failures++;
      $display("FAIL err_saturate got=%0d/%0d,%0d exp=%0d,%0d", err_count2, err_count1, err_flag2, exp_c, ERR_ON);
    end
  endtask

  task automatic test_enable();
    addr = 16'h0003; data_in = 16'h0303; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    tick();
    tick();
    checks++;
    if (data_out2 !== 16'h0303 || data_out1 !== 16'h0303 || data_valid2 !== 1'b1 || data_valid1 !== 1'b1) begin
      failures++;
      $display("FAIL en_setup got=%04h,%0d/%04h,%0d exp=0303,1", data_out2, data_valid2, data_out1, data_valid1);
    end
    enable = 1'b0; data_in = 16'h3333; write_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (data_out2 !== 16'h0303 || data_out1 !== 16'h0303 || data_valid2 !== 1'b1 || data_valid1 !== 1'b1) begin
        failures++;
        $display("FAIL en_frozen step=%0d got=%04h,%0d/%04h,%0d exp=0303,1", n, data_out2, data_valid2, data_out1, data_valid1);
      end
    end
    enable = 1'b1;
    tick();
    write_en = 1'b0;
    checks++;
    if (data_out2 !== 16'h3333 || data_out1 !== 16'h3333) begin
      failures++;
      $display("FAIL en_commit got=%04h/%04h exp=3333", data_out2, data_out1);
    end
    addr = 16'h0004; data_in = 16'h0404; write_en = 1'b1;
    tick();
    enable = 1'b0; data_in = 16'h4444;
    repeat (2) tick();
    enable = 1'b1; write_en = 1'b0;
    repeat (2) tick();
    checks++;
    if (data_out2 !== 16'h0404 || data_out1 !== 16'h0404) begin
      failures++;
      $display("FAIL en_no_write got=%04h/%04h exp=0404", data_out2, data_out1);
    end
  endtask

  task automatic test_addr_change();
    addr = 16'h0003; write_en = 1'b0;
    repeat (3) tick();
    addr = 16'h0001;
    #1;
    checks++;
    if (data_valid2 !== 1'b0 || data_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL valid_drop got=%0d/%0d exp=0", data_valid2, data_valid1);
    end
    for (int n = 1; n <= 3; n++) begin
      addr = 16'(n);
      tick();
      checks++;
      if (data_valid2 !== 1'b0 || data_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL valid_moving addr=%0d got=%0d/%0d exp=0", n, data_valid2, data_valid1);
      end
    end
    tick();
    checks++;
    if (data_valid1 !== 1'b1 || data_out1 !== 16'h3333 || data_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL hold_one got=%0d,%04h/%0d exp=1,3333/0", data_valid1, data_out1, data_valid2);
    end
    tick();
    checks++;
    if (data_valid2 !== 1'b1 || data_out2 !== 16'h3333) begin
      failures++;
      $display("FAIL hold_two got=%0d,%04h exp=1,3333", data_valid2, data_out2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_forward();
    test_out_of_range();
    test_enable();
    test_addr_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
